// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: instruction-memory request/ack bus between fetch controller and imem
interface pc_fetch_ctrl_if #(parameter int ADDR_W = 8);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    modport master (output req, output addr, input ack);
    modport slave  (input req, input addr, output ack);
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC fetch sequencer (IDLE/REQ/ISSUE/HALT); ACK_TIMEOUT_EN adds an imem ack timeout
module pc_fetch_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int STEP       = 1,
    parameter int RESET_ADDR = 0,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              halt,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_off,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    pc_fetch_ctrl_if.master   imem,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_we,
    output logic [ADDR_W-1:0] pc_cur,
    output logic              halted,
    output logic              fetch_err
);
    localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_ADDR);

    typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALT} state_t;

    state_t            state, state_nx;
    logic              upd, tmo;
    logic [ADDR_W-1:0] target;

    assign imem.req    = state == REQ;
    assign imem.addr   = pc_cur;
    assign instr_valid = state == ISSUE;
    assign halted      = state == HALT;
    assign upd         = state == ISSUE && !stall;
    assign target      = jump_en ? jump_addr : branch_en ? pc_cur + branch_off : pc_cur + STEP_V;

`ifdef ACK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          err;
    assign tmo       = state == REQ && !imem.ack && cnt == CW'(TIMEOUT - 1);
    assign fetch_err = err;
    // count unanswered REQ cycles; zero outside REQ so each REQ entry starts clean
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= (state == REQ && !imem.ack) ? cnt + 1'b1 : '0;
            err <= err | tmo;
        end
    end
`else
    assign tmo       = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? REQ : IDLE;
            REQ:     state_nx = imem.ack ? ISSUE : tmo ? HALT : REQ;
            ISSUE:   state_nx = stall ? ISSUE : halt ? HALT : REQ;
            default: state_nx = HALT;
        endcase
    end

    // state, PC and load-strobe registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc_cur  <= RESET_V;
            pc_next <= RESET_V;
            pc_we   <= 1'b0;
        end else begin
            state <= state_nx;
            pc_we <= upd;
            if (upd) begin
                pc_cur  <= target;
                pc_next <= target;
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;
    logic       clk = 0, reset = 1, start = 0, stall = 0, halt = 0, branch_en = 0, jump_en = 0;
    logic [7:0] branch_off = 0, jump_addr = 0;
    logic       instr_valid, pc_we, halted, fetch_err;
    logic [7:0] pc_next, pc_cur;
    int         checks = 0, failures = 0, we_cnt = 0;
    logic       chk_en = 0;
    logic [7:0] exp_pc = 0;
    logic       exp_req = 0, exp_iv = 0, exp_we = 0, exp_halt = 0, exp_err = 0;
    time        req_t[$];

    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.ADDR_W(8)) imem ();

    pc_fetch_ctrl #(.ADDR_W(8), .STEP(1), .RESET_ADDR(0), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
        .branch_en(branch_en), .branch_off(branch_off), .jump_en(jump_en), .jump_addr(jump_addr),
        .imem(imem), .instr_valid(instr_valid), .pc_next(pc_next), .pc_we(pc_we),
        .pc_cur(pc_cur), .halted(halted), .fetch_err(fetch_err)
    );

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // model comparison every cycle, away from the active edge
    always @(negedge clk) if (chk_en) begin
        chk("imem_req", 32'(imem.req), 32'(exp_req));
        chk("imem_addr", 32'(imem.addr), 32'(exp_pc));
        chk("pc_cur", 32'(pc_cur), 32'(exp_pc));
        chk("pc_next", 32'(pc_next), 32'(exp_pc));
        chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
        chk("pc_we", 32'(pc_we), 32'(exp_we));
        chk("halted", 32'(halted), 32'(exp_halt));
        chk("fetch_err", 32'(fetch_err), 32'(exp_err));
        if (pc_we) we_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        exp_we = 0;
    endtask

    // one instruction, entered in its REQ cycle: lat wait cycles, ack, stl stall cycles, update
    task automatic instr(int lat, int stl, logic j, logic [7:0] ja, logic b, logic [7:0] bo, logic h);
        logic [7:0] tgt;
        req_t.push_back($time);
        for (int k = 0; k < lat; k++) begin
            jump_en = 1; jump_addr = 8'h33; halt = 1;
            tick();
        end
        jump_en = 0; halt = 0;
        imem.ack = 1;
        tick();
        imem.ack = 0;
        exp_req = 0; exp_iv = 1;
        jump_en = j; jump_addr = ja; branch_en = b; branch_off = bo; halt = h;
        for (int k = 0; k < stl; k++) begin
            stall = 1; imem.ack = 1;
            tick();
        end
        stall = 0; imem.ack = 0;
        tgt = j ? ja : b ? exp_pc + bo : exp_pc + 8'd1;
        tick();
        jump_en = 0; branch_en = 0; halt = 0;
        exp_pc = tgt; exp_iv = 0; exp_we = 1; exp_req = !h; exp_halt = h;
    endtask

    initial begin
        imem.ack = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        chk_en = 1;
        chk("reset_pc_lit", 32'(pc_cur), 32'h00);
        tick();
        start = 1; tick(); start = 0; exp_req = 1;
        instr(0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("seq_addr_lit", 32'(imem.addr), 32'h01);
        instr(0, 0, 0, 8'h00, 0, 8'h00, 0);
        instr(0, 0, 0, 8'h00, 1, 8'hFC, 0);
        chk("branch_wrap_lit", 32'(imem.addr), 32'hFE);
        chk("throughput_lit", 32'(req_t[2] - req_t[0]), 32'd40);
        instr(0, 0, 0, 8'h00, 0, 8'h00, 0);
        instr(0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("seq_wrap_lit", 32'(imem.addr), 32'h00);
        instr(2, 0, 1, 8'h10, 0, 8'h00, 0);
        instr(0, 0, 1, 8'h80, 1, 8'h04, 0);
        chk("jump_prio_lit", 32'(imem.addr), 32'h80);
        instr(1, 0, 0, 8'h00, 1, 8'h05, 0);
        instr(0, 4, 1, 8'h40, 0, 8'h00, 1);
        chk("halt_pc_lit", 32'(pc_cur), 32'h40);
        start = 1; imem.ack = 1;
        repeat (4) tick();
        start = 0; imem.ack = 0;
        chk("we_count_lit", 32'(we_cnt), 32'd9);
        reset = 1; tick(); reset = 0;
        exp_pc = 0; exp_req = 0; exp_halt = 0; exp_iv = 0;
        start = 1; tick(); start = 0; exp_req = 1;
        instr(0, 0, 0, 8'h00, 0, 8'h00, 0);
        tick(); tick();
        reset = 1; tick(); reset = 0;
        exp_pc = 0; exp_req = 0;
        chk("midreq_reset_lit", 32'(imem.req), 32'h0);
        tick();
`ifdef ACK_TIMEOUT_EN
        start = 1; tick(); start = 0; exp_req = 1;
        repeat (14) tick();
        tick();
        exp_req = 0; exp_halt = 1; exp_err = 1;
        tick(); tick();
        reset = 1; tick(); reset = 0;
        exp_halt = 0; exp_err = 0;
        start = 1; tick(); start = 0; exp_req = 1;
        repeat (14) tick();
        imem.ack = 1; tick(); imem.ack = 0;
        exp_req = 0; exp_iv = 1;
        chk("late_ack_no_err_lit", 32'(fetch_err), 32'h0);
        tick();
        exp_pc = 1; exp_we = 1; exp_req = 1; exp_iv = 0;
        tick();
`endif
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
